int_ctrl: RTL and testbench
===========================

# int_ctrl

Memory-mapped interrupt controller between external interrupt sources and the CPU's `HWInt[7:2]` inputs. It synchronises six raw request lines and latches them per source as edge- or level-triggered. It applies per-source masks and a global enable, and exposes status, mask, mode, clear and software-set registers on the peripheral bus (`PrAddr`/`PrWD`/`PrWe`/`PrRD`). CP0 priority and EPC handling stay in the CPU; this block only conditions and holds the requests.

## Interface
- `BASE_ADDR`, default `32'h0000_7F20`: word-aligned byte base of the 32-byte register window. Bits [4:0] must be 0.
- `clk`  in  1  single system clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `irq_src`  in  6  raw requests; bit i drives `HWInt[i+2]`
- `PrAddr`  in  30  bus word address [31:2]
- `PrWD`  in  32  bus write data
- `PrWe`  in  1  bus write strobe; the write takes effect on the edge where `PrWe=1` and `hit=1`
- `hit`  out  1  combinational; 1 when `{PrAddr,2'b0}` lies in `BASE_ADDR..BASE_ADDR+0x1F`
- `PrRD`  out  32  combinational read data for the addressed register; 0 when `hit=0`
- `HWInt`  out  6  to CPU `HWInt[7:2]`; equals `pending & mask & {6{gie}}`, combinational from registers

## Operation
- Register map (byte offset from `BASE_ADDR`):
  - 0x00 STATUS, read-only: [5:0] `pending`, [13:8] synchronised level `sync`, all other bits 0.
  - 0x04 CTRL, read/write: [5:0] `mask`, [31] `gie`, other bits read 0.
  - 0x08 MODE, read/write: [5:0], bit=1 selects edge mode, bit=0 selects level mode.
  - 0x0C CLEAR, write-only, write-1-to-clear `pending` for edge-mode bits.
  - 0x10 SWSET, write-only, write-1-to-set `pending` for edge-mode bits.
  - 0x14 ACTIVE, read-only: [5:0] `HWInt`, [10:8] index of the lowest set `HWInt` bit, [31] any active.
  - 0x18 and 0x1C read 0; writes to them are ignored. Writes to read-only offsets are ignored. Reads of write-only offsets return 0.
- Synchroniser: `s1 <= irq_src`, `sync <= s1`. `prev <= sync` every cycle regardless of mode.
- Edge-mode bit i, next `pending[i]`:
  - set when `sync[i] & ~prev[i]`, or on a SWSET write with `PrWD[i]=1`;
  - otherwise cleared on a CLEAR write with `PrWD[i]=1`;
  - otherwise held.
  - Set wins over a simultaneous clear.
- Level-mode bit i: `pending[i] <= sync[i]` every cycle. CLEAR and SWSET have no effect on level-mode bits.
- Mode change:
  - Edge to level: `pending` follows `sync` from the next edge.
  - Level to edge: `pending` holds its current value. No spurious edge is produced, because `prev` always tracks `sync`.
- Masked sources still latch into `pending`. Unmasking a held bit asserts `HWInt` immediately, combinationally.
- Only the lower 6 bits of `PrWD` are used by CTRL, MODE, CLEAR and SWSET, plus bit 31 for CTRL.

## Timing
- Reset values: `s1`, `sync`, `prev`, `pending`, `mask`, `gie` = 0; MODE = 0 (all level). After reset, `HWInt=0` and `PrRD=0` at STATUS.
- `rst` asserted mid-operation clears all state on that edge. Writes on the same edge are discarded.
- Source to `HWInt` latency: `irq_src` rises before edge E0 → `sync` high after E1 → `pending` high after E2. `HWInt` is high after E2 if unmasked and `gie=1`.
- Register write to effect: the new value is visible in `PrRD` and `HWInt` one edge after the `PrWe` cycle.
- Reads are zero-latency (combinational) and have no side effects.
- Level-mode deassertion: `irq_src` falling before E0 gives `HWInt` low after E2.
- An edge-mode pulse of at least one clock cycle is always captured. Shorter pulses may be lost.

## Configuration
- `INTC_SYNC_EN` defined: the two-flop synchroniser is present as described above, giving 2-cycle source latency.
- `INTC_SYNC_EN` undefined: `sync = irq_src` directly. `pending` updates on E0, and `STATUS[13:8]` is the raw input. Use this only when the sources are already synchronous to `clk`.

## Test plan
- Reset, then read CTRL, MODE and STATUS → all 0. `HWInt=6'b0` with `irq_src=6'h3F`, since mask=0.
- Write CTRL=`32'h8000_0001`, MODE=0. Raise `irq_src[0]` → `HWInt=6'b000001` exactly 2 edges later (sync enabled). Drop it → `HWInt` returns to 0 2 edges later.
- MODE=`6'h04`, CTRL=`32'h8000_0004`. Pulse `irq_src[2]` for 1 cycle → `HWInt[2]` stays 1. Write CLEAR=4 → 0 next edge.
- Edge bit 3 pending, then CLEAR=8 and a new rising edge land on the same edge → `pending[3]` remains 1.
- MODE=`6'h3F`, `gie=0`. SWSET=`6'h21` → STATUS[5:0]=`6'h21` and `HWInt=0`. Set CTRL=`32'h8000_003F` → `HWInt=6'h21` and ACTIVE[10:8]=0.
- Address `BASE_ADDR+0x20` → `hit=0` and `PrRD=0`; a write there leaves all registers unchanged. Assert `rst` while `pending=6'h3F` → all registers 0 after the next edge.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller feeding CPU HWInt[7:2].
// Six request lines are conditioned per source as edge- or level-triggered,
// held in a pending register, then gated by a per-source mask and a global
// enable. The registers sit in a 32-byte window on the peripheral bus.
//
// Build option INTC_SYNC_EN: when defined, a two-flop synchroniser sits in
// front of the source logic. When undefined, the raw inputs are used
// directly, which is only safe for sources already synchronous to clk.
module int_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  irq_src,
  input  logic [29:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        PrWe,
  output logic        hit,
  output logic [31:0] PrRD,
  output logic [5:0]  HWInt
);

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_CTRL   = 3'd1;
  localparam logic [2:0] OFF_MODE   = 3'd2;
  localparam logic [2:0] OFF_CLEAR  = 3'd3;
  localparam logic [2:0] OFF_SWSET  = 3'd4;
  localparam logic [2:0] OFF_ACTIVE = 3'd5;

  logic [5:0] sync_lvl;
  logic [5:0] prev_reg;
  logic [5:0] pending_reg, pending_next;
  logic [5:0] mask_reg;
  logic [5:0] mode_reg;
  logic       gie_reg;

  logic [2:0] offset;
  logic       wr_ctrl, wr_mode, wr_clear, wr_swset;
  logic [5:0] rise, sw_set, clr_bits;
  logic [2:0] act_idx;

  // Only the low six data bits and bit 31 carry register content.
  logic unused_wd;
  assign unused_wd = &{1'b0, PrWD[30:6]};

`ifdef INTC_SYNC_EN
  logic [5:0] s1_reg, sync_reg;

  // Two-flop synchroniser for asynchronous request lines
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg   <= '0;
      sync_reg <= '0;
    end else begin
      s1_reg   <= irq_src;
      sync_reg <= s1_reg;
    end
  end

  assign sync_lvl = sync_reg;
`else
  assign sync_lvl = irq_src;
`endif

  // Address decode: the window is 8 words, so the upper 27 word-address
  // bits must match the base and the low 3 select the register.
  assign hit    = (PrAddr[29:3] == BASE_ADDR[31:5]);
  assign offset = PrAddr[2:0];

  assign wr_ctrl  = PrWe & hit & (offset == OFF_CTRL);
  assign wr_mode  = PrWe & hit & (offset == OFF_MODE);
  assign wr_clear = PrWe & hit & (offset == OFF_CLEAR);
  assign wr_swset = PrWe & hit & (offset == OFF_SWSET);

  assign sw_set   = wr_swset ? PrWD[5:0] : 6'b0;
  assign clr_bits = wr_clear ? PrWD[5:0] : 6'b0;

  // prev always tracks sync, so switching a source into edge mode never
  // sees a stale low level and cannot fabricate a rising edge.
  assign rise = sync_lvl & ~prev_reg;

  // Per-source next pending: edge sources latch (set beats clear),
  // level sources simply follow the synchronised level.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_pend
      assign pending_next[gi] = mode_reg[gi]
                              ? (rise[gi] | sw_set[gi] | (pending_reg[gi] & ~clr_bits[gi]))
                              : sync_lvl[gi];
    end
  endgenerate

  // State registers: edge history, pending requests and control fields
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg    <= '0;
      pending_reg <= '0;
      mask_reg    <= '0;
      gie_reg     <= 1'b0;
      mode_reg    <= '0;
    end else begin
      prev_reg    <= sync_lvl;
      pending_reg <= pending_next;
      if (wr_ctrl) begin
        mask_reg <= PrWD[5:0];
        gie_reg  <= PrWD[31];
      end
      if (wr_mode) begin
        mode_reg <= PrWD[5:0];
      end
    end
  end

  assign HWInt = pending_reg & mask_reg & {6{gie_reg}};

  // Index of the lowest active request (0 when none are active)
  always_comb begin
    act_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (HWInt[i]) act_idx = 3'(i);
    end
  end

  // Combinational read mux; unmapped and write-only offsets read 0
  always_comb begin
    PrRD = 32'b0;
    if (hit) begin
      case (offset)
        OFF_STATUS: PrRD = {18'b0, sync_lvl, 2'b0, pending_reg};
        OFF_CTRL:   PrRD = {gie_reg, 25'b0, mask_reg};
        OFF_MODE:   PrRD = {26'b0, mode_reg};
        OFF_ACTIVE: PrRD = {|HWInt, 20'b0, act_idx, 2'b0, HWInt};
        default:    PrRD = 32'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: self-checking bench for int_ctrl. Table-driven register
// vectors, hand-written multi-cycle sequences, then randomized traffic
// compared against a behavioural model of the controller.
module tb_int_ctrl;

  localparam logic [31:0] BASE = 32'h0000_7F20;
`ifdef INTC_SYNC_EN
  localparam int LAT = 3;  // edges from irq_src change to pending change
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq_src;
  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWe;
  logic        hit;
  logic [31:0] PrRD;
  logic [5:0]  HWInt;

  always #5 clk = ~clk;

  int_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .PrAddr(PrAddr), .PrWD(PrWD),
    .PrWe(PrWe), .hit(hit), .PrRD(PrRD), .HWInt(HWInt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;
  logic [5:0] irq_cur = '0;

  // ---------------- behavioural model ----------------
  // h[k] = irq_src value sampled k+1 edges ago (h[0] = most recent edge)
  logic [5:0] h [3];
  logic [5:0] m_pending, m_mask, m_mode;
  logic       m_gie;

  function automatic logic [5:0] m_sync();
`ifdef INTC_SYNC_EN
    return h[1];
`else
    return irq_src;
`endif
  endfunction

  function automatic logic [5:0] m_prev();
`ifdef INTC_SYNC_EN
    return h[2];
`else
    return h[0];
`endif
  endfunction

  function automatic logic m_inwin(logic [29:0] a);
    logic [31:0] b;
    b = {a, 2'b00};
    return (b >= BASE) && (b <= BASE + 32'd31);
  endfunction

  function automatic int m_off(logic [29:0] a);
    logic [31:0] b;
    b = {a, 2'b00};
    return int'((b - BASE) >> 2);
  endfunction

  function automatic logic [5:0] m_hw();
    return m_pending & m_mask & {6{m_gie}};
  endfunction

  function automatic logic [31:0] m_rd(logic [29:0] a);
    logic [5:0] hw;
    int idx;
    if (!m_inwin(a)) return 32'h0;
    hw = m_hw();
    idx = 0;
    for (int i = 0; i < 6; i++) if (hw[i] && idx == 0 && hw[idx] == 1'b0) idx = i;
    case (m_off(a))
      0: return 32'(m_sync()) * 256 + 32'(m_pending);
      1: return (m_gie ? 32'h8000_0000 : 32'h0) + 32'(m_mask);
      2: return 32'(m_mode);
      5: return (hw != 0 ? 32'h8000_0000 : 32'h0) + 32'(idx) * 256 + 32'(hw);
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_edge();
    logic [5:0] s, r, sw, cl, np;
    int off;
    if (rst) begin
      m_pending = '0; m_mask = '0; m_mode = '0; m_gie = 1'b0;
      h[0] = '0; h[1] = '0; h[2] = '0;
      return;
    end
    s  = m_sync();
    r  = s & ~m_prev();
    off = m_off(PrAddr);
    sw = (PrWe && m_inwin(PrAddr) && off == 4) ? PrWD[5:0] : 6'h0;
    cl = (PrWe && m_inwin(PrAddr) && off == 3) ? PrWD[5:0] : 6'h0;
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) np[i] = (r[i] || sw[i]) ? 1'b1 : (cl[i] ? 1'b0 : m_pending[i]);
      else           np[i] = s[i];
    end
    m_pending = np;
    if (PrWe && m_inwin(PrAddr) && off == 1) begin m_mask = PrWD[5:0]; m_gie = PrWD[31]; end
    if (PrWe && m_inwin(PrAddr) && off == 2) m_mode = PrWD[5:0];
    h[2] = h[1]; h[1] = h[0]; h[0] = irq_src;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [29:0] waddr(input int off);
    logic [29:0] b;
    b = BASE[31:2];
    return b + 30'(off);
  endfunction

  // Apply inputs just after an edge and settle to mid-cycle for checking
  task automatic set_in(input logic r, input logic [5:0] irq, input logic [29:0] a,
                        input logic we, input logic [31:0] wd);
    rst = r; irq_src = irq; PrAddr = a; PrWe = we; PrWD = wd;
    #4;
  endtask

  // Advance across one rising edge, updating the model alongside
  task automatic adv();
    $display("cyc %0d rst=%0b irq=%h addr=%h we=%0b wd=%h hit=%0b rd=%h hw=%h",
             cyc_no, rst, irq_src, PrAddr, PrWe, PrWD, hit, PrRD, HWInt);
    m_edge();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    set_in(1'b0, irq_cur, waddr(off), 1'b1, d);
    adv();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
      adv();
    end
  endtask

  task automatic rd_check(input string name, input int off, input logic [31:0] exp);
    set_in(1'b0, irq_cur, waddr(off), 1'b0, 32'h0);
    check(name, PrRD, exp);
    adv();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wd;
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic [5:0]  exp_hw;
  } vec_t;

  vec_t tv [22];

  initial begin
    // register-access vectors; irq_src held at 0, values are pre-edge
    tv[0]  = '{1'b0, waddr(1), 32'h0,         1'b1, 32'h0000_0000, 6'h00};
    tv[1]  = '{1'b0, waddr(2), 32'h0,         1'b1, 32'h0000_0000, 6'h00};
    tv[2]  = '{1'b0, waddr(0), 32'h0,         1'b1, 32'h0000_0000, 6'h00};
    tv[3]  = '{1'b1, waddr(2), 32'h0000_003F, 1'b1, 32'h0000_0000, 6'h00};
    tv[4]  = '{1'b0, waddr(2), 32'h0,         1'b1, 32'h0000_003F, 6'h00};
    tv[5]  = '{1'b1, waddr(4), 32'h0000_0021, 1'b1, 32'h0000_0000, 6'h00};
    tv[6]  = '{1'b0, waddr(0), 32'h0,         1'b1, 32'h0000_0021, 6'h00};
    tv[7]  = '{1'b1, waddr(1), 32'h8000_003F, 1'b1, 32'h0000_0000, 6'h00};
    tv[8]  = '{1'b0, waddr(5), 32'h0,         1'b1, 32'h8000_0021, 6'h21};
    tv[9]  = '{1'b0, waddr(1), 32'h0,         1'b1, 32'h8000_003F, 6'h21};
    tv[10] = '{1'b1, waddr(3), 32'h0000_0001, 1'b1, 32'h0000_0000, 6'h21};
    tv[11] = '{1'b0, waddr(5), 32'h0,         1'b1, 32'h8000_0520, 6'h20};
    tv[12] = '{1'b1, waddr(1), 32'h0000_001F, 1'b1, 32'h8000_003F, 6'h20};
    tv[13] = '{1'b0, waddr(6), 32'h0,         1'b1, 32'h0000_0000, 6'h00};
    tv[14] = '{1'b1, waddr(6), 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 6'h00};
    tv[15] = '{1'b1, waddr(0), 32'hFFFF_FFFF, 1'b1, 32'h0000_0020, 6'h00};
    tv[16] = '{1'b0, waddr(0), 32'h0,         1'b1, 32'h0000_0020, 6'h00};
    tv[17] = '{1'b1, waddr(2), 32'h0000_0000, 1'b1, 32'h0000_003F, 6'h00};
    tv[18] = '{1'b0, waddr(0), 32'h0,         1'b1, 32'h0000_0020, 6'h00};
    tv[19] = '{1'b0, waddr(0), 32'h0,         1'b1, 32'h0000_0000, 6'h00};
    tv[20] = '{1'b1, waddr(8), 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 6'h00};
    tv[21] = '{1'b0, waddr(1), 32'h0,         1'b1, 32'h0000_001F, 6'h00};

    // ---- reset and post-reset state ----
    set_in(1'b1, 6'h00, waddr(0), 1'b0, 32'h0);
    adv();
    irq_cur = 6'h00;
    set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
    check("rst_hw", {26'b0, HWInt}, 32'h0);
    adv();
    rd_check("rst_ctrl", 1, 32'h0);
    rd_check("rst_mode", 2, 32'h0);
    rd_check("rst_status", 0, 32'h0);
    irq_cur = 6'h3F;
    idle(LAT + 1);
    set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
    check("masked_hw", {26'b0, HWInt}, 32'h0);
    check("masked_pending", PrRD & 32'h3F, 32'h3F);
    adv();
    irq_cur = 6'h00;
    idle(LAT + 1);

    // ---- level mode latency on source 0 ----
    wr(1, 32'h8000_0001);
    wr(2, 32'h0);
    irq_cur = 6'h01;
    for (int k = 0; k <= LAT; k++) begin
      set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
      check($sformatf("lvl_rise_%0d", k), {26'b0, HWInt}, (k >= LAT) ? 32'h1 : 32'h0);
      adv();
    end
    irq_cur = 6'h00;
    for (int k = 0; k <= LAT; k++) begin
      set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
      check($sformatf("lvl_fall_%0d", k), {26'b0, HWInt}, (k >= LAT) ? 32'h0 : 32'h1);
      adv();
    end

    // ---- one-cycle pulse captured in edge mode, then cleared ----
    wr(2, 32'h0000_0004);
    wr(1, 32'h8000_0004);
    irq_cur = 6'h04;
    idle(1);
    irq_cur = 6'h00;
    idle(LAT + 2);
    set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
    check("edge_hold", {26'b0, HWInt}, 32'h4);
    adv();
    wr(3, 32'h0000_0004);
    set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
    check("edge_clear", {26'b0, HWInt}, 32'h0);
    adv();

    // ---- set beats a simultaneous clear on source 3 ----
    wr(2, 32'h0000_0008);
    wr(4, 32'h0000_0008);
    rd_check("swset3", 0, 32'h0000_0008);
    irq_cur = 6'h08;
    idle(LAT - 1);
    wr(3, 32'h0000_0008);          // clear on the same edge as the detected rise
    set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
    check("set_wins", PrRD & 32'h3F, 32'h8);
    adv();
    wr(3, 32'h0000_0008);          // steady level: the clear now takes effect
    set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
    check("clear_no_rise", PrRD & 32'h3F, 32'h0);
    adv();
    irq_cur = 6'h00;
    idle(LAT + 1);

    // ---- software set with gie off, then reset while all pending ----
    wr(2, 32'h0000_003F);
    wr(1, 32'h0000_003F);
    wr(4, 32'h0000_0021);
    set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
    check("swset_status", PrRD & 32'h3F, 32'h21);
    check("swset_gie0_hw", {26'b0, HWInt}, 32'h0);
    adv();
    wr(1, 32'h8000_003F);
    set_in(1'b0, irq_cur, waddr(5), 1'b0, 32'h0);
    check("unmask_hw", {26'b0, HWInt}, 32'h21);
    check("active_idx", (PrRD >> 8) & 32'h7, 32'h0);
    adv();
    wr(4, 32'h0000_003F);
    set_in(1'b0, irq_cur, waddr(0), 1'b0, 32'h0);
    check("all_pending", {26'b0, HWInt}, 32'h3F);
    adv();
    set_in(1'b1, irq_cur, waddr(1), 1'b1, 32'h8000_0001);
    adv();
    rd_check("post_rst_ctrl", 1, 32'h0);
    rd_check("post_rst_mode", 2, 32'h0);
    rd_check("post_rst_status", 0, 32'h0);

    // ---- table vectors ----
    set_in(1'b1, 6'h00, waddr(0), 1'b0, 32'h0);
    adv();
    for (int i = 0; i < 22; i++) begin
      set_in(1'b0, 6'h00, tv[i].addr, tv[i].we, tv[i].wd);
      check($sformatf("tv%0d_hit", i), {31'b0, hit}, {31'b0, tv[i].exp_hit});
      check($sformatf("tv%0d_rd", i), PrRD, tv[i].exp_rd);
      check($sformatf("tv%0d_hw", i), {26'b0, HWInt}, {26'b0, tv[i].exp_hw});
      adv();
    end

    // ---- randomized traffic against the model ----
    set_in(1'b1, 6'h00, waddr(0), 1'b0, 32'h0);
    adv();
    irq_cur = 6'h00;
    for (int n = 0; n < 250; n++) begin
      logic        r;
      logic [29:0] a;
      int          off;
      r = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) irq_cur = 6'($urandom);
      off = $urandom_range(0, 9);
      if (off == 9)      a = 30'($urandom);
      else               a = waddr(off);
      set_in(r, irq_cur, a, 1'($urandom_range(0, 1)), $urandom);
      check($sformatf("rnd%0d_hit", n), {31'b0, hit}, {31'b0, m_inwin(a)});
      check($sformatf("rnd%0d_rd", n), PrRD, m_rd(a));
      check($sformatf("rnd%0d_hw", n), {26'b0, HWInt}, {26'b0, m_hw()});
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
